udp_tx_sched: RTL and testbench
===============================

// Module: udp_tx_sched
// PURPOSE
//  Round-robin scheduler sharing the single UDP TX path (mac fs/fd handshake + fifod2mac byte read port) between NCH frame sources.
//  Each source holds one byte FIFO plus a length; the scheduler grants one source, drives the length and start, routes FIFO reads/data, then returns done.
//  Sits between per-source FIFOs (gmii_txc domain) and fifod2mac/mac; replaces the hard-wired single-source fs_udp_tx hookup.
// PARAMETERS
//  NCH      4     number of requesting sources (2..8)
//  LEN_W    12    width of payload length (bytes)
//  MAX_LEN  1472  largest legal payload; larger or zero is rejected
//  GAP_CYC  12    idle cycles enforced between consecutive frames
//  TO_CYC   65535 watchdog limit in cycles for mac_fd (TX_TIMEOUT_EN only)
// PORTS
//  clk        in   1          gmii_txc domain clock
//  rst        in   1          asynchronous reset, active-low (0 = reset)
//  ch_fs      in   NCH        per-source frame start; level, held until matching ch_fd seen
//  ch_len     in   NCH*LEN_W  per-source payload length; slice i = [i*LEN_W +: LEN_W]; stable while ch_fs[i]=1
//  ch_fd      out  NCH        per-source done; level, high from completion until ch_fs[i] drops
//  ch_rxen    out  NCH        per-source FIFO read enable (only granted bit may be 1)
//  ch_rxd     in   NCH*8      per-source FIFO read data
//  mac_fs     out  1          to fifod2mac/mac fs: level, held until mac_fd
//  mac_fd     in   1          from mac fd
//  mac_len    out  LEN_W      to data_len / udp_tx_len; registered, stable while mac_fs=1
//  mac_rxen   in   1          read enable from fifod2mac (fifod_rxen)
//  mac_rxd    out  8          read data to fifod2mac (fifod_rxd)
//  grant      out  NCH        one-hot current owner, 0 when idle
//  busy       out  1          1 in any state except IDLE
//  err        out  1          one-cycle pulse: length reject or (if enabled) timeout
//  frame_cnt  out  16         frames completed OK, wraps 0xFFFF -> 0
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, all outputs 0, rr pointer=0, gap counter=0.
//  States: IDLE -> ARB -> SEND -> DONE -> GAP -> IDLE; ARB -> DONE on length reject.
//  IDLE: wait for any ch_fs[i]=1 with ch_fd[i]=0 (a source still holding fs after its fd is not eligible).
//  ARB (1 cycle): pick first eligible index at or after rr pointer, wrapping mod NCH; latch grant, mac_len=ch_len[sel].
//   len==0 or len>MAX_LEN -> err pulse, go DONE without touching mac (ch_fd still raised, frame_cnt unchanged).
//  SEND: mac_fs=1; ch_rxen = grant & {NCH{mac_rxen}} (combinational); mac_rxd = ch_rxd[sel] (combinational mux, 0 when idle).
//   mac_fd=1 -> mac_fs=0 next cycle, frame_cnt+1, go DONE.
//  DONE: ch_fd[sel]=1, held until ch_fs[sel]=0; then clear ch_fd, grant=0, rr pointer=sel+1 mod NCH, go GAP.
//  GAP: count GAP_CYC cycles (GAP_CYC=0 -> straight to IDLE); requests arriving here wait.
//  Latency: ch_fs rise in IDLE -> mac_fs=1 exactly 2 cycles later.
//  Simultaneous requests: lowest index at/after pointer wins; losers keep fs high and are served in later rounds; no starvation.
//  Granted source dropping ch_fs during SEND: ignored; frame completes, DONE then exits immediately.
//  ch_len changes after ARB: ignored (mac_len latched).
//  mac_fd while not in SEND: ignored.
// CONFIGURATION
//  TX_TIMEOUT_EN defined: watchdog counts SEND cycles; reaching TO_CYC -> mac_fs=0, err pulse, go DONE, frame_cnt unchanged.
//  TX_TIMEOUT_EN undefined: no watchdog; SEND waits for mac_fd forever; no counter logic synthesised.
// STRUCTURE
//  Package udp_tx_sched_pkg: state encoding (IDLE=1,ARB=2,SEND=3,DONE=4,GAP=5, 4-bit localparams), UDP_MAX_PAYLOAD=1472 constant.
//  Sub-module rr_arb: NCH-wide round-robin picker (req, ptr in; one-hot gnt and index out), purely combinational.
//  Top holds FSM, len latch, gap/timeout counters, data/enable mux.
// TESTING
//  1 src: ch_fs[0]=1, len=12, mac_fd after 40 cyc -> mac_fs=1 2 cyc later, mac_len=12, ch_fd[0]=1, frame_cnt=1.
//  All 4 fs high together, ptr=0 -> grants 0,1,2,3 in order, each separated by >=12 idle cycles.
//  Grant=2, mac_rxen pulses x12, ch_rxd[2]=0xA0..0xAB -> mac_rxd matches, only ch_rxen[2] toggles.
//  ch_len[1]=0 then 1500 -> err pulse each, ch_fd[1] raised, mac_fs never asserted, frame_cnt unchanged.
//  rst=0 mid-SEND -> all outputs 0 immediately; after release, pending fs re-arbitrated from ptr 0.
//  TX_TIMEOUT_EN, TO_CYC=100, no mac_fd -> mac_fs drops at cycle 100 of SEND, err pulse, ch_fd set.

Source files
------------

// File: rtl/udp_tx_sched_pkg.sv
// Shared constants for the UDP TX scheduler: FSM state encoding and the
// largest UDP payload that fits a standard 1500-byte Ethernet MTU.
package udp_tx_sched_pkg;

  // 4-bit state encoding, kept numeric for compatibility with older tooling
  localparam logic [3:0] ST_IDLE = 4'd1;
  localparam logic [3:0] ST_ARB  = 4'd2;
  localparam logic [3:0] ST_SEND = 4'd3;
  localparam logic [3:0] ST_DONE = 4'd4;
  localparam logic [3:0] ST_GAP  = 4'd5;

  // 1500 MTU - 20 IP header - 8 UDP header
  localparam int UDP_MAX_PAYLOAD = 1472;

endpackage

// File: rtl/udp_tx_sched_rr_arb.sv
// Round-robin picker: grants the first requester at or after ptr, wrapping
// modulo NCH. Purely combinational; the caller registers the result.
module rr_arb #(
  parameter int NCH   = 4,
  parameter int PTR_W = $clog2(NCH)
) (
  input  logic [NCH-1:0]   req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NCH-1:0]   gnt,
  output logic [PTR_W-1:0] idx,
  output logic             vld
);

  // Scan from ptr upward; the first hit wins and masks later candidates
  always_comb begin
    int j;
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      j = (int'(ptr) + k) % NCH;
      if (!vld && req[j]) begin
        gnt[j] = 1'b1;
        idx    = PTR_W'(j);
        vld    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/udp_tx_sched.sv
// udp_tx_sched: shares one UDP TX path (mac fs/fd handshake plus the
// fifod2mac byte read port) between NCH frame sources, round-robin.
// Optional feature: define TX_TIMEOUT_EN to add a mac_fd watchdog of
// TO_CYC SEND cycles; without it SEND waits for mac_fd indefinitely.
module udp_tx_sched
  import udp_tx_sched_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int LEN_W   = 12,
  parameter int MAX_LEN = UDP_MAX_PAYLOAD,
  parameter int GAP_CYC = 12
`ifdef TX_TIMEOUT_EN
  ,
  parameter int TO_CYC  = 65535
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NCH-1:0]     ch_fs,
  input  logic [NCH*LEN_W-1:0] ch_len,
  output logic [NCH-1:0]     ch_fd,
  output logic [NCH-1:0]     ch_rxen,
  input  logic [NCH*8-1:0]   ch_rxd,
  output logic               mac_fs,
  input  logic               mac_fd,
  output logic [LEN_W-1:0]   mac_len,
  input  logic               mac_rxen,
  output logic [7:0]         mac_rxd,
  output logic [NCH-1:0]     grant,
  output logic               busy,
  output logic               err,
  output logic [15:0]        frame_cnt
);

  localparam int PTR_W = $clog2(NCH);
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  logic [3:0]       state_reg;
  logic [NCH-1:0]   grant_reg;
  logic [NCH-1:0]   ch_fd_reg;
  logic [PTR_W-1:0] sel_reg;
  logic [PTR_W-1:0] ptr_reg;
  logic [LEN_W-1:0] mac_len_reg;
  logic             mac_fs_reg;
  logic             err_reg;
  logic [15:0]      frame_cnt_reg;
  logic [GAP_W-1:0] gap_cnt_reg;

  logic [LEN_W-1:0] len_arr [NCH];
  logic [7:0]       rxd_arr [NCH];

  logic [NCH-1:0]   eligible;
  logic [NCH-1:0]   arb_gnt;
  logic [PTR_W-1:0] arb_idx;
  logic             arb_vld;
  logic [LEN_W-1:0] len_sel;
  logic             len_bad;
  logic [PTR_W-1:0] ptr_next;

  // Unpack the flat per-source buses into arrays for indexed muxing
  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_unpack
      assign len_arr[gi] = ch_len[gi*LEN_W +: LEN_W];
      assign rxd_arr[gi] = ch_rxd[gi*8 +: 8];
    end
  endgenerate

  // A source that still holds fs after its fd is waiting to drop, not asking again
  assign eligible = ch_fs & ~ch_fd_reg;

  rr_arb #(.NCH(NCH), .PTR_W(PTR_W)) u_arb (
    .req (eligible),
    .ptr (ptr_reg),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .vld (arb_vld)
  );

  assign len_sel  = len_arr[arb_idx];
  assign len_bad  = (len_sel == '0) || (len_sel > LEN_W'(MAX_LEN));
  assign ptr_next = (sel_reg == PTR_W'(NCH - 1)) ? '0 : sel_reg + PTR_W'(1);

`ifdef TX_TIMEOUT_EN
  localparam int TO_W = $clog2(TO_CYC + 1);
  logic [TO_W-1:0] to_cnt_reg;
  logic            to_hit;

  // Watchdog: counts cycles spent in SEND, cleared everywhere else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) to_cnt_reg <= '0;
    else if (state_reg == ST_SEND) to_cnt_reg <= to_cnt_reg + TO_W'(1);
    else to_cnt_reg <= '0;
  end

  assign to_hit = (to_cnt_reg == TO_W'(TO_CYC - 1));
`endif

  // Main scheduler FSM: arbitrate, hand the TX path to one source, then pace frames
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      grant_reg     <= '0;
      ch_fd_reg     <= '0;
      sel_reg       <= '0;
      ptr_reg       <= '0;
      mac_len_reg   <= '0;
      mac_fs_reg    <= 1'b0;
      err_reg       <= 1'b0;
      frame_cnt_reg <= '0;
      gap_cnt_reg   <= '0;
    end else begin
      err_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (|eligible) state_reg <= ST_ARB;
        end
        ST_ARB: begin
          if (!arb_vld) begin
            state_reg <= ST_IDLE;
          end else begin
            grant_reg <= arb_gnt;
            sel_reg   <= arb_idx;
            if (len_bad) begin
              // Rejected frames never reach the MAC but still complete the source handshake
              err_reg   <= 1'b1;
              ch_fd_reg <= arb_gnt;
              state_reg <= ST_DONE;
            end else begin
              mac_len_reg <= len_sel;
              mac_fs_reg  <= 1'b1;
              state_reg   <= ST_SEND;
            end
          end
        end
        ST_SEND: begin
          if (mac_fd) begin
            mac_fs_reg    <= 1'b0;
            frame_cnt_reg <= frame_cnt_reg + 16'd1;
            ch_fd_reg     <= grant_reg;
            state_reg     <= ST_DONE;
          end
`ifdef TX_TIMEOUT_EN
          else if (to_hit) begin
            mac_fs_reg <= 1'b0;
            err_reg    <= 1'b1;
            ch_fd_reg  <= grant_reg;
            state_reg  <= ST_DONE;
          end
`endif
        end
        ST_DONE: begin
          // Hold fd until the source acknowledges by dropping fs
          if (!ch_fs[sel_reg]) begin
            ch_fd_reg   <= '0;
            grant_reg   <= '0;
            ptr_reg     <= ptr_next;
            gap_cnt_reg <= '0;
            state_reg   <= (GAP_CYC == 0) ? ST_IDLE : ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_cnt_reg == GAP_W'(GAP_CYC - 1)) state_reg <= ST_IDLE;
          else gap_cnt_reg <= gap_cnt_reg + GAP_W'(1);
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign ch_rxen   = (state_reg == ST_SEND) ? (grant_reg & {NCH{mac_rxen}}) : '0;
  assign mac_rxd   = (|grant_reg) ? rxd_arr[sel_reg] : 8'd0;
  assign ch_fd     = ch_fd_reg;
  assign mac_fs    = mac_fs_reg;
  assign mac_len   = mac_len_reg;
  assign grant     = grant_reg;
  assign busy      = (state_reg != ST_IDLE);
  assign err       = err_reg;
  assign frame_cnt = frame_cnt_reg;

endmodule

// File: tb/tb_udp_tx_sched.sv
// Directed bench for udp_tx_sched (NCH=4, LEN_W=12, MAX_LEN=1472, GAP_CYC=12;
// TO_CYC=100 when TX_TIMEOUT_EN is defined).
`timescale 1ns/1ps
module tb_udp_tx_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  ch_fs;
  logic [47:0] ch_len;
  logic [3:0]  ch_fd;
  logic [3:0]  ch_rxen;
  logic [31:0] ch_rxd;
  logic        mac_fs;
  logic        mac_fd;
  logic [11:0] mac_len;
  logic        mac_rxen;
  logic [7:0]  mac_rxd;
  logic [3:0]  grant;
  logic        busy;
  logic        err;
  logic [15:0] frame_cnt;

  int vectors     = 0;
  int miscompares = 0;

  udp_tx_sched #(
    .NCH(4), .LEN_W(12), .MAX_LEN(1472), .GAP_CYC(12)
`ifdef TX_TIMEOUT_EN
    , .TO_CYC(100)
`endif
  ) dut (
    .clk(clk), .rst(rst),
    .ch_fs(ch_fs), .ch_len(ch_len), .ch_fd(ch_fd), .ch_rxen(ch_rxen), .ch_rxd(ch_rxd),
    .mac_fs(mac_fs), .mac_fd(mac_fd), .mac_len(mac_len), .mac_rxen(mac_rxen), .mac_rxd(mac_rxd),
    .grant(grant), .busy(busy), .err(err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_fs(output int w);
    w = 0;
    while (mac_fs !== 1'b1 && w < 400) begin @(negedge clk); w++; end
  endtask

  task automatic wait_idle(output int w);
    w = 0;
    while (busy !== 1'b0 && w < 400) begin @(negedge clk); w++; end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; ch_fs = '0; mac_fd = 1'b0; mac_rxen = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(1);
  endtask

  task automatic test_reset();
    ch_fs = '0; ch_len = '0; ch_rxd = 32'hDEADBEEF; mac_fd = 1'b0; mac_rxen = 1'b1;
    rst = 1'b0;
    tick(2);
    vectors++;
    if ({mac_fs, busy, err, grant, ch_fd, ch_rxen} !== 15'd0) begin
      miscompares++; $display("FAIL rst_ctrl: got %b expected 0", {mac_fs, busy, err, grant, ch_fd, ch_rxen});
    end
    vectors++;
    if (mac_len !== 12'd0 || frame_cnt !== 16'd0) begin
      miscompares++; $display("FAIL rst_regs: got len=%0d cnt=%0d expected 0/0", mac_len, frame_cnt);
    end
    vectors++;
    if (mac_rxd !== 8'd0) begin
      miscompares++; $display("FAIL rst_rxd: got %h expected 00", mac_rxd);
    end
    rst = 1'b1; mac_rxen = 1'b0;
    tick(2);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL rst_idle: busy got %b expected 0", busy);
    end
  endtask

  task automatic test_single();
    int w;
    do_reset();
    ch_len[11:0] = 12'd12;
    ch_fs[0] = 1'b1;
    tick(1);
    vectors++;
    if (mac_fs !== 1'b0 || busy !== 1'b1) begin
      miscompares++; $display("FAIL lat1: fs=%b busy=%b expected 0/1", mac_fs, busy);
    end
    tick(1);
    vectors++;
    if (mac_fs !== 1'b1 || mac_len !== 12'd12 || grant !== 4'b0001) begin
      miscompares++; $display("FAIL lat2: fs=%b len=%0d grant=%b expected 1/12/0001", mac_fs, mac_len, grant);
    end
    ch_len[11:0] = 12'd99;
    tick(40);
    vectors++;
    if (mac_fs !== 1'b1 || mac_len !== 12'd12) begin
      miscompares++; $display("FAIL hold: fs=%b len=%0d expected 1/12", mac_fs, mac_len);
    end
    mac_fd = 1'b1;
    tick(1);
    mac_fd = 1'b0;
    vectors++;
    if (mac_fs !== 1'b0 || ch_fd !== 4'b0001 || frame_cnt !== 16'd1) begin
      miscompares++; $display("FAIL single_done: fs=%b fd=%b cnt=%0d expected 0/0001/1", mac_fs, ch_fd, frame_cnt);
    end
    tick(3);
    vectors++;
    if (ch_fd !== 4'b0001) begin
      miscompares++; $display("FAIL fd_hold: got %b expected 0001", ch_fd);
    end
    ch_fs[0] = 1'b0;
    tick(1);
    vectors++;
    if (ch_fd !== 4'b0000 || grant !== 4'b0000 || busy !== 1'b1) begin
      miscompares++; $display("FAIL done_exit: fd=%b grant=%b busy=%b expected 0000/0000/1", ch_fd, grant, busy);
    end
    tick(11);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++; $display("FAIL gap11: busy got %b expected 1", busy);
    end
    tick(1);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL gap12: busy got %b expected 0", busy);
    end
    mac_fd = 1'b1;
    tick(2);
    mac_fd = 1'b0;
    vectors++;
    if (busy !== 1'b0 || frame_cnt !== 16'd1) begin
      miscompares++; $display("FAIL stray_fd: busy=%b cnt=%0d expected 0/1", busy, frame_cnt);
    end
    $display("single: src=0 len=12 frames=%0d", frame_cnt);
    wait_idle(w);
  endtask

  task automatic test_round_robin();
    int w;
    logic [3:0] exp_g;
    do_reset();
    for (int i = 0; i < 4; i++) ch_len[i*12 +: 12] = 12'(10 + i);
    ch_fs = 4'hF;
    for (int k = 0; k < 4; k++) begin
      exp_g = 4'b0001 << k;
      wait_fs(w);
      vectors++;
      if (w >= 400) begin
        miscompares++; $display("FAIL rr_wait%0d: mac_fs never rose within %0d cycles", k, w);
      end
      vectors++;
      if (grant !== exp_g || mac_len !== 12'(10 + k)) begin
        miscompares++; $display("FAIL rr_grant%0d: grant=%b len=%0d expected %b/%0d", k, grant, mac_len, exp_g, 10 + k);
      end
      vectors++;
      if ((k == 0 && w != 2) || (k > 0 && w < 12)) begin
        miscompares++; $display("FAIL rr_spacing%0d: got %0d idle cycles expected %s", k, w, (k == 0) ? "2" : ">=12");
      end
      $display("rr: frame src=%0d len=%0d after %0d cycles", k, mac_len, w);
      mac_fd = 1'b1;
      tick(1);
      mac_fd = 1'b0;
      vectors++;
      if (ch_fd !== exp_g) begin
        miscompares++; $display("FAIL rr_fd%0d: got %b expected %b", k, ch_fd, exp_g);
      end
      ch_fs[k] = 1'b0;
    end
    wait_idle(w);
    vectors++;
    if (frame_cnt !== 16'd4) begin
      miscompares++; $display("FAIL rr_count: got %0d expected 4", frame_cnt);
    end
  endtask

  task automatic test_data_mux();
    int w;
    do_reset();
    ch_rxd = 32'h5A5A_5A5A;
    ch_len[24 +: 12] = 12'd12;
    ch_fs[2] = 1'b1;
    #1;
    vectors++;
    if (mac_rxd !== 8'd0) begin
      miscompares++; $display("FAIL mux_idle: got %h expected 00", mac_rxd);
    end
    wait_fs(w);
    vectors++;
    if (grant !== 4'b0100) begin
      miscompares++; $display("FAIL mux_grant: got %b expected 0100", grant);
    end
    for (int i = 0; i < 12; i++) begin
      ch_rxd = {8'(8'h31 + i), 8'(8'hA0 + i), 8'(8'h13 * i), 8'(8'hF0 - i)};
      mac_rxen = 1'b1;
      #1;
      vectors++;
      if (mac_rxd !== 8'(8'hA0 + i) || ch_rxen !== 4'b0100) begin
        miscompares++; $display("FAIL mux_byte%0d: rxd=%h rxen=%b expected %h/0100", i, mac_rxd, ch_rxen, 8'(8'hA0 + i));
      end
      tick(1);
      mac_rxen = 1'b0;
      #1;
      vectors++;
      if (ch_rxen !== 4'b0000) begin
        miscompares++; $display("FAIL mux_off%0d: rxen=%b expected 0000", i, ch_rxen);
      end
      tick(1);
    end
    $display("mux: src=2 12 bytes streamed");
    mac_fd = 1'b1;
    tick(1);
    mac_fd = 1'b0;
    ch_fs = '0;
    wait_idle(w);
  endtask

  task automatic test_len_reject();
    int w;
    logic [15:0] fc0;
    logic [11:0] bad_len [3] = '{12'd0, 12'd1500, 12'd1473};
    for (int t = 0; t < 3; t++) begin
      fc0 = frame_cnt;
      ch_len[12 +: 12] = bad_len[t];
      ch_fs[1] = 1'b1;
      tick(1);
      vectors++;
      if (err !== 1'b0) begin
        miscompares++; $display("FAIL rej_arb%0d: err got %b expected 0", t, err);
      end
      tick(1);
      vectors++;
      if (err !== 1'b1 || ch_fd !== 4'b0010 || mac_fs !== 1'b0) begin
        miscompares++; $display("FAIL rej_pulse%0d: err=%b fd=%b fs=%b expected 1/0010/0", t, err, ch_fd, mac_fs);
      end
      tick(1);
      vectors++;
      if (err !== 1'b0 || mac_fs !== 1'b0 || ch_fd !== 4'b0010) begin
        miscompares++; $display("FAIL rej_after%0d: err=%b fs=%b fd=%b expected 0/0/0010", t, err, mac_fs, ch_fd);
      end
      ch_fs[1] = 1'b0;
      wait_idle(w);
      vectors++;
      if (w >= 400 || frame_cnt !== fc0) begin
        miscompares++; $display("FAIL rej_cnt%0d: cnt=%0d wait=%0d expected %0d", t, frame_cnt, w, fc0);
      end
      $display("reject: len=%0d", bad_len[t]);
    end
    fc0 = frame_cnt;
    ch_len[12 +: 12] = 12'd1472;
    ch_fs[1] = 1'b1;
    wait_fs(w);
    vectors++;
    if (w != 2 || mac_len !== 12'd1472 || err !== 1'b0) begin
      miscompares++; $display("FAIL max_len: wait=%0d len=%0d err=%b expected 2/1472/0", w, mac_len, err);
    end
    mac_fd = 1'b1;
    tick(1);
    mac_fd = 1'b0;
    vectors++;
    if (frame_cnt !== fc0 + 16'd1) begin
      miscompares++; $display("FAIL max_cnt: got %0d expected %0d", frame_cnt, fc0 + 16'd1);
    end
    ch_fs[1] = 1'b0;
    wait_idle(w);
  endtask

  task automatic test_reset_mid_send();
    int w;
    ch_len[12 +: 12] = 12'd30;
    ch_len[36 +: 12] = 12'd40;
    ch_fs = 4'b1010;
    wait_fs(w);
    vectors++;
    if (grant !== 4'b1000 || mac_len !== 12'd40) begin
      miscompares++; $display("FAIL pre_rst: grant=%b len=%0d expected 1000/40", grant, mac_len);
    end
    tick(5);
    mac_rxen = 1'b1;
    #1;
    vectors++;
    if (ch_rxen !== 4'b1000) begin
      miscompares++; $display("FAIL pre_rst_rxen: got %b expected 1000", ch_rxen);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if ({mac_fs, busy, err, grant, ch_fd, ch_rxen} !== 15'd0 || mac_len !== 12'd0 || frame_cnt !== 16'd0) begin
      miscompares++; $display("FAIL mid_rst: ctrl=%b len=%0d cnt=%0d expected 0", {mac_fs, busy, err, grant, ch_fd, ch_rxen}, mac_len, frame_cnt);
    end
    tick(2);
    rst = 1'b1;
    mac_rxen = 1'b0;
    wait_fs(w);
    vectors++;
    if (w != 2 || grant !== 4'b0010 || mac_len !== 12'd30) begin
      miscompares++; $display("FAIL post_rst: wait=%0d grant=%b len=%0d expected 2/0010/30", w, grant, mac_len);
    end
    $display("reset: re-arbitrated to src=1");
    mac_fd = 1'b1;
    tick(1);
    mac_fd = 1'b0;
    ch_fs[1] = 1'b0;
    wait_fs(w);
    mac_fd = 1'b1;
    tick(1);
    mac_fd = 1'b0;
    ch_fs = '0;
    wait_idle(w);
  endtask

`ifdef TX_TIMEOUT_EN
  task automatic test_timeout();
    int w;
    int hi;
    do_reset();
    ch_len[11:0] = 12'd20;
    ch_fs[0] = 1'b1;
    wait_fs(w);
    hi = 0;
    while (mac_fs === 1'b1 && hi < 200) begin tick(1); hi++; end
    vectors++;
    if (hi != 100) begin
      miscompares++; $display("FAIL to_len: mac_fs high %0d cycles expected 100", hi);
    end
    vectors++;
    if (err !== 1'b1 || ch_fd !== 4'b0001 || frame_cnt !== 16'd0) begin
      miscompares++; $display("FAIL to_done: err=%b fd=%b cnt=%0d expected 1/0001/0", err, ch_fd, frame_cnt);
    end
    tick(1);
    vectors++;
    if (err !== 1'b0) begin
      miscompares++; $display("FAIL to_pulse: err got %b expected 0", err);
    end
    $display("timeout: src=0 after %0d cycles", hi);
    ch_fs = '0;
    wait_idle(w);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_data_mux();
    test_len_reject();
    test_reset_mid_send();
`ifdef TX_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
    $fatal(1, "bench timeout");
  end

endmodule
